// File: rtl/datapath_unit.sv
// Single-bus 32-bit datapath slice: bus mux, register bank, Y/Z and ALU.
// Build option: define ALU_LOGIC_EN to enable the SUB/AND/OR ALU ops.
module datapath_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 PCout,
  input  logic                 Zlowout,
  input  logic                 MDRout,
  input  logic                 R2out,
  input  logic                 R4out,
  input  logic                 MARin,
  input  logic                 Zin,
  input  logic                 PCin,
  input  logic                 MDRin,
  input  logic                 IRin,
  input  logic                 Yin,
  input  logic                 R2in,
  input  logic                 R4in,
  input  logic                 R5in,
  input  logic                 IncPC,
  input  logic                 read,
  input  logic                 ADD,
  input  logic                 SUB,
  input  logic                 AND,
  input  logic                 OR,
  input  logic [WIDTH-1:0]     Mdatain,
  output logic [WIDTH-1:0]     R0,
  output logic [WIDTH-1:0]     R1,
  output logic [WIDTH-1:0]     R2,
  output logic [WIDTH-1:0]     R3,
  output logic [WIDTH-1:0]     R4,
  output logic [WIDTH-1:0]     R5,
  output logic [WIDTH-1:0]     R6,
  output logic [WIDTH-1:0]     R7,
  output logic [WIDTH-1:0]     R8,
  output logic [WIDTH-1:0]     R9,
  output logic [WIDTH-1:0]     R10,
  output logic [WIDTH-1:0]     R11,
  output logic [WIDTH-1:0]     R12,
  output logic [WIDTH-1:0]     R13,
  output logic [WIDTH-1:0]     R14,
  output logic [WIDTH-1:0]     R15,
  output logic [WIDTH-1:0]     Hi,
  output logic [WIDTH-1:0]     Lo,
  output logic [WIDTH-1:0]     PC,
  output logic [WIDTH-1:0]     MDR,
  output logic [WIDTH-1:0]     IR,
  output logic [WIDTH-1:0]     bus_mux_out,
  output logic [2*WIDTH-1:0]   Z,
  output logic [2*WIDTH-1:0]   ALUout
);

  logic [WIDTH-1:0]   r_pc;
  logic [WIDTH-1:0]   r_ir;
  logic [WIDTH-1:0]   r_mar;
  logic [WIDTH-1:0]   r_mdr;
  logic [WIDTH-1:0]   r_y;
  logic [2*WIDTH-1:0] r_z;
  logic [WIDTH-1:0]   r_r2;
  logic [WIDTH-1:0]   r_r4;
  logic [WIDTH-1:0]   r_r5;

  logic [WIDTH-1:0]   w_bus;
  logic [WIDTH-1:0]   w_mdr_d;
  logic [2*WIDTH-1:0] w_alu;
  logic [2*WIDTH-1:0] w_sext_a;
  logic [2*WIDTH-1:0] w_sext_b;
  logic               w_unused_bits;

  // Overlapping selects resolve by fixed priority, not one-hot.
  always_comb begin
    w_bus = '0;
    if (PCout)        w_bus = r_pc;
    else if (Zlowout) w_bus = r_z[WIDTH-1:0];
    else if (MDRout)  w_bus = r_mdr;
    else if (R2out)   w_bus = r_r2;
    else if (R4out)   w_bus = r_r4;
  end

  assign w_sext_a = {{WIDTH{r_y[WIDTH-1]}}, r_y};
  assign w_sext_b = {{WIDTH{w_bus[WIDTH-1]}}, w_bus};

  always_comb begin
    w_alu = '0;
    if (IncPC)
      w_alu = {{WIDTH{1'b0}}, w_bus + WIDTH'(1)};
    else if (ADD)
      w_alu = w_sext_a + w_sext_b;
`ifdef ALU_LOGIC_EN
    else if (SUB)
      w_alu = w_sext_a - w_sext_b;
    else if (AND)
      w_alu = {{WIDTH{1'b0}}, r_y & w_bus};
    else if (OR)
      w_alu = {{WIDTH{1'b0}}, r_y | w_bus};
`endif
  end

`ifdef ALU_LOGIC_EN
  assign w_unused_bits = ^r_mar;
`else
  assign w_unused_bits = ^{r_mar, SUB, AND, OR};
`endif

  assign w_mdr_d = read ? Mdatain : w_bus;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc  <= '0;
      r_ir  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_y   <= '0;
      r_z   <= '0;
      r_r2  <= '0;
      r_r4  <= '0;
      r_r5  <= '0;
    end else begin
      if (PCin)  r_pc  <= w_bus;
      if (IRin)  r_ir  <= w_bus;
      if (MARin) r_mar <= w_bus;
      if (MDRin) r_mdr <= w_mdr_d;
      if (Yin)   r_y   <= w_bus;
      if (Zin)   r_z   <= w_alu;
      if (R2in)  r_r2  <= w_bus;
      if (R4in)  r_r4  <= w_bus;
      if (R5in)  r_r5  <= w_bus;
    end
  end

  // Registers without a load path read as constant zero.
  assign R0  = '0;
  assign R1  = '0;
  assign R2  = r_r2;
  assign R3  = '0;
  assign R4  = r_r4;
  assign R5  = r_r5;
  assign R6  = '0;
  assign R7  = '0;
  assign R8  = '0;
  assign R9  = '0;
  assign R10 = '0;
  assign R11 = '0;
  assign R12 = '0;
  assign R13 = '0;
  assign R14 = '0;
  assign R15 = '0;
  assign Hi  = '0;
  assign Lo  = '0;

  assign PC          = r_pc;
  assign MDR         = r_mdr;
  assign IR          = r_ir;
  assign bus_mux_out = w_bus;
  assign Z           = r_z;
  assign ALUout      = w_alu;

endmodule

// File: tb/tb_datapath_unit.sv
// Directed self-checking bench for datapath_unit.
// Logic-op expectations follow the ALU_LOGIC_EN build option.
module tb_datapath_unit;

  logic        clk;
  logic        reset;
  logic        PCout, Zlowout, MDRout, R2out, R4out;
  logic        MARin, Zin, PCin, MDRin, IRin, Yin;
  logic        R2in, R4in, R5in;
  logic        IncPC, read, ADD, SUB, AND, OR;
  logic [31:0] Mdatain;
  logic [31:0] R0, R1, R2, R3, R4, R5, R6, R7;
  logic [31:0] R8, R9, R10, R11, R12, R13, R14, R15;
  logic [31:0] Hi, Lo, PC, MDR, IR, bus_mux_out;
  logic [63:0] Z, ALUout;

  int n_checks;
  int n_fail;

  datapath_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout),
    .R2out(R2out), .R4out(R4out),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin),
    .IRin(IRin), .Yin(Yin),
    .R2in(R2in), .R4in(R4in), .R5in(R5in),
    .IncPC(IncPC), .read(read),
    .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR),
    .Mdatain(Mdatain),
    .R0(R0), .R1(R1), .R2(R2), .R3(R3),
    .R4(R4), .R5(R5), .R6(R6), .R7(R7),
    .R8(R8), .R9(R9), .R10(R10), .R11(R11),
    .R12(R12), .R13(R13), .R14(R14), .R15(R15),
    .Hi(Hi), .Lo(Lo), .PC(PC), .MDR(MDR), .IR(IR),
    .bus_mux_out(bus_mux_out), .Z(Z), .ALUout(ALUout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic ctl_clear();
    {PCout, Zlowout, MDRout, R2out, R4out} = '0;
    {MARin, Zin, PCin, MDRin, IRin, Yin} = '0;
    {R2in, R4in, R5in} = '0;
    {IncPC, read, ADD, SUB, AND, OR} = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ctl_clear();
  endtask

  task automatic load_mdr(input logic [31:0] d);
    Mdatain = d; read = 1'b1; MDRin = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [32*21-1:0] all;
    reset = 1'b1;
    ctl_clear();
    Mdatain = '0;
    repeat (2) @(posedge clk);
    #1;
    all = {R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10,
           R11, R12, R13, R14, R15, Hi, Lo, PC, MDR, IR};
    n_checks++;
    if (all !== '0) begin
      n_fail++; $display("FAIL reset_regs: got nonzero, want 0");
    end
    n_checks++;
    if ({Z, ALUout, bus_mux_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_z: Z=%h ALU=%h bus=%h want 0", Z, ALUout, bus_mux_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_mdr_loads();
    logic [31:0] v [3];
    v[0] = 32'h22; v[1] = 32'h24; v[2] = 32'h26;
    for (int i = 0; i < 3; i++) begin
      load_mdr(v[i]);
      n_checks++;
      if (MDR !== v[i]) begin
        n_fail++; $display("FAIL mdr_load%0d: got %h want %h", i, MDR, v[i]);
      end
      MDRout = 1'b1;
      R2in = (i == 0); R4in = (i == 1); R5in = (i == 2);
      step();
    end
    n_checks++;
    if ({R2, R4, R5} !== {32'h22, 32'h24, 32'h26}) begin
      n_fail++; $display("FAIL reg_load: got %h %h %h want 22 24 26", R2, R4, R5);
    end
  endtask

  task automatic test_fetch();
    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
    #1;
    n_checks++;
    if (ALUout !== 64'h1) begin
      n_fail++; $display("FAIL fetch_alu: got %h want 1", ALUout);
    end
    step();
    n_checks++;
    if (Z !== 64'h1) begin
      n_fail++; $display("FAIL fetch_z: got %h want 1", Z);
    end
    Zlowout = 1'b1; PCin = 1'b1;
    read = 1'b1; MDRin = 1'b1; Mdatain = 32'h4A92_0000;
    step();
    n_checks++;
    if (PC !== 32'h1 || MDR !== 32'h4A92_0000) begin
      n_fail++; $display("FAIL fetch_pc_mdr: got %h %h want 1 4a920000", PC, MDR);
    end
    MDRout = 1'b1; IRin = 1'b1;
    step();
    n_checks++;
    if (IR !== 32'h4A92_0000) begin
      n_fail++; $display("FAIL fetch_ir: got %h want 4a920000", IR);
    end
  endtask

  task automatic test_add();
    R2out = 1'b1; Yin = 1'b1;
    step();
    R4out = 1'b1; ADD = 1'b1; Zin = 1'b1;
    step();
    n_checks++;
    if (Z !== 64'h46) begin
      n_fail++; $display("FAIL add_z: got %h want 46", Z);
    end
    Zlowout = 1'b1; R5in = 1'b1;
    step();
    n_checks++;
    if (R5 !== 32'h46) begin
      n_fail++; $display("FAIL add_r5: got %h want 46", R5);
    end
  endtask

  task automatic test_logic();
    logic [63:0] exp_sub, exp_and, exp_or;
`ifdef ALU_LOGIC_EN
    exp_sub = 64'hFFFF_FFFF_FFFF_FFFE;
    exp_and = 64'h0000_0000_F000_F000;
    exp_or  = 64'h0000_0000_FFF0_FFF0;
`else
    exp_sub = '0; exp_and = '0; exp_or = '0;
`endif
    load_mdr(32'h5);
    MDRout = 1'b1; Yin = 1'b1;
    step();
    load_mdr(32'h7);
    MDRout = 1'b1; SUB = 1'b1;
    #1;
    n_checks++;
    if (ALUout !== exp_sub) begin
      n_fail++; $display("FAIL sub: got %h want %h", ALUout, exp_sub);
    end
    ctl_clear();
    load_mdr(32'hF0F0_F0F0);
    MDRout = 1'b1; Yin = 1'b1;
    step();
    load_mdr(32'hFF00_FF00);
    MDRout = 1'b1; AND = 1'b1;
    #1;
    n_checks++;
    if (ALUout !== exp_and) begin
      n_fail++; $display("FAIL and: got %h want %h", ALUout, exp_and);
    end
    AND = 1'b0; OR = 1'b1;
    #1;
    n_checks++;
    if (ALUout !== exp_or) begin
      n_fail++; $display("FAIL or: got %h want %h", ALUout, exp_or);
    end
    OR = 1'b0; ADD = 1'b1;
    #1;
    n_checks++;
    if (ALUout !== 64'hFFFF_FFFF_EFF1_EFF0) begin
      n_fail++; $display("FAIL add_signed: got %h want ffffffffeff1eff0", ALUout);
    end
    ctl_clear();
  endtask

  task automatic test_priority();
    PCout = 1'b1; MDRout = 1'b1;
    #1;
    n_checks++;
    if (bus_mux_out !== 32'h1) begin
      n_fail++; $display("FAIL prio_pc: got %h want 1", bus_mux_out);
    end
    PCout = 1'b0; Zlowout = 1'b1;
    #1;
    n_checks++;
    if (bus_mux_out !== 32'h46) begin
      n_fail++; $display("FAIL prio_z: got %h want 46", bus_mux_out);
    end
    ctl_clear();
    R2out = 1'b1; R4out = 1'b1;
    #1;
    n_checks++;
    if (bus_mux_out !== 32'h22) begin
      n_fail++; $display("FAIL prio_r2: got %h want 22", bus_mux_out);
    end
    ctl_clear();
    #1;
    n_checks++;
    if (bus_mux_out !== 32'h0 || ALUout !== 64'h0) begin
      n_fail++; $display("FAIL idle: bus %h alu %h want 0", bus_mux_out, ALUout);
    end
    MDRout = 1'b1; IncPC = 1'b1; ADD = 1'b1;
    #1;
    n_checks++;
    if (ALUout !== 64'h0000_0000_FF00_FF01) begin
      n_fail++; $display("FAIL inc_over_add: got %h want ff00ff01", ALUout);
    end
    ctl_clear();
    load_mdr(32'hFFFF_FFFF);
    MDRout = 1'b1; IncPC = 1'b1;
    #1;
    n_checks++;
    if (ALUout !== 64'h0) begin
      n_fail++; $display("FAIL inc_wrap: got %h want 0", ALUout);
    end
    ctl_clear();
  endtask

  task automatic test_hold();
    logic [32*18-1:0] fixed;
    read = 1'b1; Mdatain = 32'h1234_5678;
    step();
    n_checks++;
    if (MDR !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL mdr_hold: got %h want ffffffff", MDR);
    end
    fixed = {R0, R1, R3, R6, R7, R8, R9, R10, R11,
             R12, R13, R14, R15, Hi, Lo, 32'h0, 32'h0, 32'h0};
    n_checks++;
    if (fixed !== '0) begin
      n_fail++; $display("FAIL noload_regs: got nonzero want 0");
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 2; i++) begin
      Zlowout = 1'b1; IncPC = 1'b1; Zin = 1'b1;
      step();
      n_checks++;
      if (Z !== 64'h46 + 64'(i)) begin
        n_fail++; $display("FAIL z_selfinc%0d: got %h want %h", i, Z, 64'h46 + 64'(i));
      end
    end
  endtask

  task automatic test_async_reset();
    R2out = 1'b1;
    #1;
    n_checks++;
    if (bus_mux_out !== 32'h22) begin
      n_fail++; $display("FAIL pre_reset_bus: got %h want 22", bus_mux_out);
    end
    reset = 1'b1;
    #2;
    n_checks++;
    if ({R2, R4, R5, PC, MDR, IR, bus_mux_out} !== '0 || Z !== '0) begin
      n_fail++;
      $display("FAIL async_reset: R2 %h PC %h MDR %h IR %h Z %h bus %h want 0",
               R2, PC, MDR, IR, Z, bus_mux_out);
    end
    reset = 1'b0;
    ctl_clear();
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_mdr_loads();
    test_fetch();
    test_add();
    test_logic();
    test_priority();
    test_hold();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/datapath_unit.md
Name: datapath_unit

Overview:
- Single-bus 32-bit CPU datapath slice.
- Contains PC, IR, MAR, MDR, Y, a 64-bit Z, register file outputs R0–R15, Hi/Lo, and an ALU.
- External control signals gate register drivers onto a shared bus and latch registers from it.
- Sits under the control unit; memory data enters through Mdatain.

Parameters:
- WIDTH, 32, bus/register width (Z and ALUout are 2*WIDTH).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-high reset
- PCout, Zlowout, MDRout, R2out, R4out  in  1 each  bus driver selects
- MARin, Zin, PCin, MDRin, IRin, Yin, R2in, R4in, R5in  in  1 each  register load enables
- IncPC  in  1  ALU computes bus+1
- read  in  1  MDR source = Mdatain (else bus)
- ADD, SUB, AND, OR  in  1 each  ALU op selects
- Mdatain  in  32  memory read data
- R0..R15, Hi, Lo, PC, MDR, IR  out  32 each  register contents
- bus_mux_out  out  32  current bus value
- Z  out  64  Z register
- ALUout  out  64  combinational ALU result

Behaviour:
- Reset (async, active-high): every register (R0–R15, Hi, Lo, PC, IR, MAR, MDR, Y, Z) clears to 0 immediately. Reset overrides all loads.
- Bus (combinational) uses fixed priority when several selects are high: PCout > Zlowout > MDRout > R2out > R4out.
  - Sources in that order: PC, Z[31:0], MDR, R2, R4.
  - No select high -> bus = 0.
- Register loads occur on posedge clk when the enable is high; data comes from the bus.
  - Enables: PCin->PC, IRin->IR, MARin->MAR (internal), Yin->Y, R2in/R4in/R5in->R2/R4/R5.
- MDR: on posedge with MDRin=1, loads Mdatain if read=1, else the bus. MDRin=0 holds MDR regardless of read.
- Z: on posedge with Zin=1, loads ALUout.
- R0, R1, R3, R6–R15, Hi, Lo have no load path. They hold 0 after reset.
- ALU (combinational), A = Y, B = bus, one-hot op priority IncPC > ADD > SUB > AND > OR:
  - IncPC: {32'b0, B+1} (32-bit wrap: 0xFFFFFFFF -> 0).
  - ADD: sign-extend A and B to 64 bits, then 64-bit sum.
  - SUB: sign-extended A-B.
  - AND: {32'b0, A&B}.
  - OR: {32'b0, A|B}.
  - No op high: 0.
- Simultaneous load and drive of the same register in one cycle: the register captures the pre-edge bus value (normal flop behaviour).
- No internal state machine. One-cycle latency from enable to register update; Z and ALUout are visible the same cycle via combinational paths.

Optional Feature:
- Macro ALU_LOGIC_EN.
  - Defined: SUB, AND, OR behave as above.
  - Undefined: only IncPC and ADD are implemented. SUB/AND/OR inputs are ignored and ALUout = 0 when only they are asserted. Ports remain present.

Test Plan:
- Reset mid-run with R2=0x22 -> all outputs 0 asynchronously, before the next clock edge.
- Mdatain=0x22, read+MDRin one edge, then MDRout+R2in one edge -> MDR=0x22, R2=0x22. Repeat with 0x24->R4 and 0x26->R5.
- Fetch: PCout+MARin+IncPC+Zin -> Z=0x1. Then Zlowout+PCin, with read+MDRin and Mdatain=0x4A920000 -> PC=1, MDR=0x4A920000. Then MDRout+IRin -> IR=0x4A920000.
- ADD: R2out+Yin (Y=0x22), then R4out+ADD+Zin -> Z=0x46. Then Zlowout+R5in -> R5=0x46.
- Signed ops (ALU_LOGIC_EN): Y=0x00000005, bus=0x00000007, SUB -> ALUout=0xFFFFFFFFFFFFFFFE. AND of 0xF0F0F0F0/0xFF00FF00 -> 0xF000F000. OR -> 0xFFF0FFF0.
- Priority/idle: PCout and MDRout high together -> bus=PC. No select -> bus=0. IncPC with ADD -> B+1. IncPC with bus=0xFFFFFFFF -> ALUout=0.
